// File: rtl/block_lock_ctrl.sv
// ----------------------------------------------------------------------------
// block_lock_ctrl
//   Block-lock controller for a 64b/66b receive path. It watches the 2-bit
//   sync header of every block coming out of the 64b-to-66b converter, issues
//   one-cycle bit-slip requests until headers line up, and then reports
//   block_lock. Once locked, lock is held until too many invalid headers
//   arrive inside one test window.
//
// Ports
//   clk                clock
//   reset_n            asynchronous active-low reset
//   enable_i           controller enable; low parks the FSM in INIT
//   sh_valid_i         one new block header is present on sh_i this cycle
//   sh_i               sync header (01/10 valid, 00/11 invalid)
//   slip_o             one-cycle request to shift converter alignment by 1 bit
//   block_lock_o       lock achieved
//   slip_count_o       total slips issued, saturating
//   lock_loss_count_o  number of falling edges of block_lock_o, saturating
//
// All outputs are registered: a strobe sampled in cycle N shows its effect
// in cycle N+1.
// ----------------------------------------------------------------------------
module block_lock_ctrl #(
   parameter int SH_WINDOW     = 64,
   parameter int INVALID_LIMIT = 16,
   parameter int SLIP_HOLDOFF  = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable_i,
   input  logic             sh_valid_i,
   input  logic [1:0]       sh_i,
   output logic             slip_o,
   output logic             block_lock_o,
   output logic [CNT_W-1:0] slip_count_o,
   output logic [CNT_W-1:0] lock_loss_count_o
);

   // Counter widths: each counter must hold its terminal value itself.
   localparam int SH_W  = $clog2(SH_WINDOW + 1);
   localparam int INV_W = $clog2(INVALID_LIMIT + 1);
   localparam int HO_W  = (SLIP_HOLDOFF > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;

   localparam logic [SH_W-1:0]  SH_WIN_C  = SH_W'(SH_WINDOW);
   localparam logic [INV_W-1:0] INV_LIM_C = INV_W'(INVALID_LIMIT);
   localparam logic [HO_W-1:0]  HOLD_C    = HO_W'(SLIP_HOLDOFF);
   localparam logic [HO_W-1:0]  HOLD_ONE  = HO_W'(1);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_TEST    = 2'd1,
      ST_SLIP    = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   state_t            state,      state_nxt;
   logic [SH_W-1:0]   sh_cnt,     sh_cnt_nxt;
   logic [INV_W-1:0]  inv_cnt,    inv_cnt_nxt;
   logic [HO_W-1:0]   hold_cnt,   hold_cnt_nxt;
   logic              lock_nxt;
   logic              slip_nxt;
   logic [CNT_W-1:0]  slip_cnt_nxt;
   logic [CNT_W-1:0]  loss_cnt_nxt;

   logic              hdr_bad;
   logic [SH_W-1:0]   sh_inc;
   logic [INV_W-1:0]  inv_inc;
   logic [CNT_W-1:0]  slip_sat_inc;
   logic [CNT_W-1:0]  loss_sat_inc;

   // 00 and 11 are not legal sync headers.
   assign hdr_bad = (sh_i[1] == sh_i[0]);

   // Post-increment views; the TEST rules are judged on these.
   assign sh_inc  = sh_cnt + 1'b1;
   assign inv_inc = hdr_bad ? (inv_cnt + 1'b1) : inv_cnt;

   // Saturating increments: add 1 unless already all-ones.
   assign slip_sat_inc = slip_count_o      + {{(CNT_W-1){1'b0}}, ~&slip_count_o};
   assign loss_sat_inc = lock_loss_count_o + {{(CNT_W-1){1'b0}}, ~&lock_loss_count_o};

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_INIT;
         sh_cnt            <= '0;
         inv_cnt           <= '0;
         hold_cnt          <= '0;
         block_lock_o      <= 1'b0;
         slip_o            <= 1'b0;
         slip_count_o      <= '0;
         lock_loss_count_o <= '0;
      end else begin
         state             <= state_nxt;
         sh_cnt            <= sh_cnt_nxt;
         inv_cnt           <= inv_cnt_nxt;
         hold_cnt          <= hold_cnt_nxt;
         block_lock_o      <= lock_nxt;
         slip_o            <= slip_nxt;
         slip_count_o      <= slip_cnt_nxt;
         lock_loss_count_o <= loss_cnt_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      sh_cnt_nxt   = sh_cnt;
      inv_cnt_nxt  = inv_cnt;
      hold_cnt_nxt = hold_cnt;
      lock_nxt     = block_lock_o;
      slip_nxt     = 1'b0;          // slip is a single-cycle pulse
      slip_cnt_nxt = slip_count_o;
      loss_cnt_nxt = lock_loss_count_o;

      if (!enable_i) begin
         // Disable overrides everything; statistics are kept.
         state_nxt    = ST_INIT;
         lock_nxt     = 1'b0;
         sh_cnt_nxt   = '0;
         inv_cnt_nxt  = '0;
         hold_cnt_nxt = '0;
      end else begin
         unique case (state)
            ST_INIT: begin
               lock_nxt    = 1'b0;
               sh_cnt_nxt  = '0;
               inv_cnt_nxt = '0;
               state_nxt   = ST_TEST;
            end

            ST_TEST: begin
               if (sh_valid_i) begin
                  if (hdr_bad && (!block_lock_o || (inv_inc == INV_LIM_C))) begin
                     // Slip takes priority over a coincident window end.
                     state_nxt    = ST_SLIP;
                     lock_nxt     = 1'b0;
                     slip_nxt     = 1'b1;
                     slip_cnt_nxt = slip_sat_inc;
                     sh_cnt_nxt   = '0;
                     inv_cnt_nxt  = '0;
                  end else if (sh_inc == SH_WIN_C) begin
                     // Window closed without a slip: a clean window grants
                     // lock, a tolerated-error window just restarts.
                     if (inv_inc == '0) begin
                        lock_nxt = 1'b1;
                     end
                     sh_cnt_nxt  = '0;
                     inv_cnt_nxt = '0;
                  end else begin
                     sh_cnt_nxt  = sh_inc;
                     inv_cnt_nxt = inv_inc;
                  end
               end
            end

            ST_SLIP: begin
               // Any strobe in this cycle is deliberately dropped: the
               // converter has not applied the new alignment yet.
               hold_cnt_nxt = HOLD_C;
               sh_cnt_nxt   = '0;
               inv_cnt_nxt  = '0;
               state_nxt    = (SLIP_HOLDOFF == 0) ? ST_TEST : ST_HOLDOFF;
            end

            ST_HOLDOFF: begin
               if (hold_cnt == '0) begin
                  state_nxt = ST_TEST;
               end else if (sh_valid_i) begin
                  hold_cnt_nxt = hold_cnt - 1'b1;
                  if (hold_cnt == HOLD_ONE) begin
                     state_nxt = ST_TEST;
                  end
               end
            end

            default: begin
               state_nxt = ST_INIT;
               lock_nxt  = 1'b0;
            end
         endcase
      end

      // Count every falling edge of lock, whatever caused it.
      if (block_lock_o && !lock_nxt) begin
         loss_cnt_nxt = loss_sat_inc;
      end
   end

endmodule

// File: tb/tb_block_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_block_lock_ctrl
//   Directed self-checking bench for block_lock_ctrl with default parameters
//   (64-header window, 16-invalid limit, 4-strobe holdoff). Inputs change 1ns
//   after the rising edge; outputs are read at the same point, so each read
//   reflects the strobe sampled on the edge just passed.
// ----------------------------------------------------------------------------
module tb_block_lock_ctrl;

   localparam int CNT_W = 16;

   logic             clk;
   logic             reset_n;
   logic             enable_i;
   logic             sh_valid_i;
   logic [1:0]       sh_i;
   logic             slip_o;
   logic             block_lock_o;
   logic [CNT_W-1:0] slip_count_o;
   logic [CNT_W-1:0] lock_loss_count_o;

   int n_chk;
   int n_pass;
   int slip_cycles;

   block_lock_ctrl #(
      .SH_WINDOW    (64),
      .INVALID_LIMIT(16),
      .SLIP_HOLDOFF (4),
      .CNT_W        (CNT_W)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable_i         (enable_i),
      .sh_valid_i       (sh_valid_i),
      .sh_i             (sh_i),
      .slip_o           (slip_o),
      .block_lock_o     (block_lock_o),
      .slip_count_o     (slip_count_o),
      .lock_loss_count_o(lock_loss_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of cycles slip_o was seen high; must equal the number of slips
   // if every pulse is exactly one cycle wide.
   always @(negedge clk) begin
      if (slip_o) slip_cycles = slip_cycles + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One header strobe, then settle 1ns past the edge that sampled it.
   task automatic send(input logic [1:0] h);
      sh_valid_i = 1'b1;
      sh_i       = h;
      @(posedge clk);
      #1;
      sh_valid_i = 1'b0;
      sh_i       = 2'b00;
   endtask

   task automatic send_n(input int n, input logic [1:0] h);
      for (int i = 0; i < n; i++) send(h);
   endtask

   task automatic idle(input int n);
      sh_valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic lk, input logic sl,
                          input int sc, input int lc);
      chk({tag, ".lock"}, 32'(block_lock_o),      32'(lk));
      chk({tag, ".slip"}, 32'(slip_o),            32'(sl));
      chk({tag, ".scnt"}, 32'(slip_count_o),      32'(sc));
      chk({tag, ".lcnt"}, 32'(lock_loss_count_o), 32'(lc));
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      slip_cycles = 0;
      reset_n     = 1'b0;
      enable_i    = 1'b0;
      sh_valid_i  = 1'b0;
      sh_i        = 2'b00;
      idle(3);
      chk_out("reset", 1'b0, 1'b0, 0, 0);
      reset_n = 1'b1;
      idle(2);
      chk_out("disabled", 1'b0, 1'b0, 0, 0);

      // INIT -> TEST
      enable_i = 1'b1;
      idle(1);

      // Unlocked slip: a single bad header slips on the very next cycle.
      send_n(10, 2'b01);
      chk_out("pre_slip", 1'b0, 1'b0, 0, 0);
      send(2'b11);
      chk_out("unl_slip", 1'b0, 1'b1, 1, 0);
      idle(1);                              // SLIP -> HOLDOFF
      chk_out("unl_after", 1'b0, 1'b0, 1, 0);
      send_n(4, 2'b11);                     // swallowed by holdoff
      chk_out("holdoff_ign", 1'b0, 1'b0, 1, 0);
      send(2'b00);                          // 5th strobe is tested again
      chk_out("resume", 1'b0, 1'b1, 2, 0);
      idle(1);
      send_n(4, 2'b01);

      // Lock acquisition: 64 clean headers.
      send_n(63, 2'b01);
      chk_out("acq63", 1'b0, 1'b0, 2, 0);
      send(2'b10);
      chk_out("acq64", 1'b1, 1'b0, 2, 0);

      // Three windows with 15 invalid headers each keep lock.
      for (int w = 0; w < 3; w++) begin
         send_n(15, 2'b11);
         send_n(49, 2'b01);
         chk_out("tol_win", 1'b1, 1'b0, 2, 0);
      end

      // Loss of lock: 16th invalid header within one window.
      send_n(15, 2'b00);
      chk_out("loss15", 1'b1, 1'b0, 2, 0);
      send(2'b11);
      chk_out("loss16", 1'b0, 1'b1, 3, 1);
      idle(1);
      chk_out("loss_after", 1'b0, 1'b0, 3, 1);
      send_n(4, 2'b01);
      send_n(64, 2'b01);
      chk_out("relock1", 1'b1, 1'b0, 3, 1);

      // 16th invalid header is also the 64th of the window: slip wins.
      send_n(48, 2'b01);
      send_n(15, 2'b11);
      chk_out("sim63", 1'b1, 1'b0, 3, 1);
      send(2'b11);
      chk_out("sim64", 1'b0, 1'b1, 4, 2);
      idle(1);
      send_n(4, 2'b10);
      // Window counters restarted: lock needs a full fresh window.
      send_n(63, 2'b10);
      chk_out("relock63", 1'b0, 1'b0, 4, 2);
      send(2'b10);
      chk_out("relock64", 1'b1, 1'b0, 4, 2);

      // Disable while locked: lock drops next cycle, statistics kept.
      enable_i = 1'b0;
      idle(1);
      chk_out("disable", 1'b0, 1'b0, 4, 3);
      idle(2);
      chk_out("disable_hold", 1'b0, 1'b0, 4, 3);
      enable_i = 1'b1;
      idle(1);
      send(2'b11);
      chk_out("reen_slip", 1'b0, 1'b1, 5, 3);
      idle(1);
      chk("slip_width", 32'(slip_cycles), 32'd5);
      send(2'b01);                          // mid-HOLDOFF

      // Asynchronous reset between edges clears everything at once.
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("mid_reset", 1'b0, 1'b0, 0, 0);
      idle(1);
      reset_n = 1'b1;
      idle(1);

      // In-flight slip pulse is cut short by reset.
      send(2'b11);
      chk_out("slip2", 1'b0, 1'b1, 1, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("slip_trunc", 1'b0, 1'b0, 0, 0);
      reset_n = 1'b1;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
